// File: rtl/if_stage_pkg.sv
// Shared fetch-stage types and constants: datapath width, reset PC, NOP encoding
// and the fetch queue entry layout.
package if_stage_pkg;

   localparam int unsigned DATA_WIDTH = 64;

   localparam logic [DATA_WIDTH-1:0] PC_RESET_DEFAULT = 64'h0000_0000_8000_0000;
   localparam logic [31:0]           INST_NOP         = 32'h0000_0013;

   typedef struct packed {
      logic [31:0]           inst;
      logic [DATA_WIDTH-1:0] pc;
   } fetch_entry_t;

endpackage

// File: rtl/if_fetch_queue.sv
// Synchronous FIFO of fetch entries with flush; flush wins over push and pop.
module if_fetch_queue
   import if_stage_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   input  logic                         push,
   input  fetch_entry_t                 push_data,
   input  logic                         pop,
   output fetch_entry_t                 head,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   fetch_entry_t   mem [DEPTH];
   logic [PW-1:0]  rd_ptr;
   logic [PW-1:0]  wr_ptr;
   logic           do_push;
   logic           do_pop;

   always_comb begin
      do_push = push && (count != CW'(DEPTH));
      do_pop  = pop && (count != '0);
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: head is only observed while count is non-zero.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   assign head = mem[rd_ptr];

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, credit-limited in-order imem requests, fetch queue
// towards decode, and redirect handling that drops responses still in flight.
module if_stage
   import if_stage_pkg::*;
#(
   parameter logic [DATA_WIDTH-1:0] PC_RESET        = PC_RESET_DEFAULT,
   parameter int unsigned           FQ_DEPTH        = 2,
   parameter int unsigned           MAX_OUTSTANDING = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  redirect_valid,
   input  logic [DATA_WIDTH-1:0] redirect_pc,
   output logic                  imem_req_valid,
   output logic [DATA_WIDTH-1:0] imem_req_addr,
   input  logic                  imem_req_ready,
   input  logic                  imem_resp_valid,
   input  logic [31:0]           imem_resp_data,
   output logic                  id_valid,
   output logic [31:0]           id_inst,
   output logic [DATA_WIDTH-1:0] id_pc,
   input  logic                  id_ready
);

   localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
   localparam int unsigned QW = $clog2(FQ_DEPTH + 1);

   logic [DATA_WIDTH-1:0] pc_q, pc_d;
   logic [DATA_WIDTH-1:0] resp_pc_q, resp_pc_d;
   logic [CW-1:0]         outstanding_q, outstanding_d;
   logic [CW-1:0]         drop_q, drop_d;
   logic [DATA_WIDTH-1:0] redirect_target;
   logic [31:0]           credit_used;
   logic                  req_fire;
   logic                  resp_push;
   logic                  fq_pop;
   logic [QW-1:0]         fq_count;
   fetch_entry_t          fq_head;
   fetch_entry_t          fq_push_data;

   // Credits count live responses plus queued entries, so every response has a slot.
   always_comb begin
      credit_used    = 32'(outstanding_q) - 32'(drop_q) + 32'(fq_count);
      imem_req_valid = !rst && !redirect_valid
                       && (32'(outstanding_q) < MAX_OUTSTANDING)
                       && (credit_used < FQ_DEPTH);
      imem_req_addr  = pc_q;
      req_fire       = imem_req_valid && imem_req_ready;
      resp_push      = imem_resp_valid && (drop_q == '0) && !redirect_valid;
      redirect_target = redirect_pc & ~DATA_WIDTH'(3);
   end

   always_comb begin
      pc_d          = pc_q;
      resp_pc_d     = resp_pc_q;
      outstanding_d = outstanding_q;
      drop_d        = drop_q;
      if (redirect_valid) begin
         pc_d          = redirect_target;
         resp_pc_d     = redirect_target;
         outstanding_d = outstanding_q - CW'(imem_resp_valid);
         drop_d        = outstanding_q - CW'(imem_resp_valid);
      end else begin
         if (req_fire) pc_d = pc_q + DATA_WIDTH'(4);
         if (req_fire && !imem_resp_valid) begin
            outstanding_d = outstanding_q + CW'(1);
         end else if (!req_fire && imem_resp_valid) begin
            outstanding_d = outstanding_q - CW'(1);
         end
         if (imem_resp_valid) begin
            if (drop_q != '0) drop_d = drop_q - CW'(1);
            else resp_pc_d = resp_pc_q + DATA_WIDTH'(4);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q          <= PC_RESET;
         resp_pc_q     <= PC_RESET;
         outstanding_q <= '0;
         drop_q        <= '0;
      end else begin
         pc_q          <= pc_d;
         resp_pc_q     <= resp_pc_d;
         outstanding_q <= outstanding_d;
         drop_q        <= drop_d;
      end
   end

   always_comb begin
      fq_push_data.inst = imem_resp_data;
      fq_push_data.pc   = resp_pc_q;
      id_valid          = (fq_count != '0);
      id_inst           = id_valid ? fq_head.inst : '0;
      id_pc             = id_valid ? fq_head.pc : '0;
      fq_pop            = id_valid && id_ready && !redirect_valid;
   end

   if_fetch_queue #(
      .DEPTH (FQ_DEPTH)
   ) u_fq (
      .clk       (clk),
      .rst       (rst),
      .flush     (redirect_valid),
      .push      (resp_push),
      .push_data (fq_push_data),
      .pop       (fq_pop),
      .head      (fq_head),
      .count     (fq_count)
   );

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: imem model with holdable responses and a scoreboard
// of expected {inst, pc} pushed at request accept and popped at decode handshake.
module tb_if_stage;
   import if_stage_pkg::*;

   localparam int unsigned FQ_DEPTH        = 2;
   localparam int unsigned MAX_OUTSTANDING = 2;
   localparam logic [63:0] PC_RESET        = 64'h0000_0000_8000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        imem_req_valid;
   logic [63:0] imem_req_addr;
   logic        imem_req_ready;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        id_valid;
   logic [31:0] id_inst;
   logic [63:0] id_pc;
   logic        id_ready;

   int checks = 0;
   int errors = 0;

   fetch_entry_t sb[$];
   logic [63:0]  pend[$];
   logic [63:0]  exp_pc = PC_RESET;
   logic         hold = 1'b0;
   logic         q_overflow = 1'b0;
   logic         out_overflow = 1'b0;

   always #5 clk = ~clk;

   if_stage #(
      .PC_RESET        (PC_RESET),
      .FQ_DEPTH        (FQ_DEPTH),
      .MAX_OUTSTANDING (MAX_OUTSTANDING)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc),
      .imem_req_valid  (imem_req_valid),
      .imem_req_addr   (imem_req_addr),
      .imem_req_ready  (imem_req_ready),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .id_valid        (id_valid),
      .id_inst         (id_inst),
      .id_pc           (id_pc),
      .id_ready        (id_ready)
   );

   function automatic logic [31:0] mem_word(input logic [63:0] a);
      logic [31:0] idx;
      idx = (a[31:0] - 32'h8000_0000) >> 2;
      return 32'h0010_0093 + idx * 32'h0010_0080;
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One clock: sample/score at negedge, then drive the next imem response.
   task automatic tick();
      fetch_entry_t e;
      logic         fire;
      logic         rst_s;
      logic [63:0]  addr;
      fire = 1'b0;
      addr = '0;
      @(negedge clk);
      rst_s = rst;
      if (dut.u_fq.push && (dut.u_fq.count == 2'(FQ_DEPTH)) && !dut.u_fq.pop && !dut.u_fq.flush)
         q_overflow = 1'b1;
      if (rst_s) begin
         sb.delete();
         exp_pc = PC_RESET;
      end else begin
         if (imem_req_valid) check("req_addr", imem_req_addr, exp_pc);
         fire = imem_req_valid && imem_req_ready;
         addr = exp_pc;
         if (redirect_valid) begin
            check("req_during_redirect", {63'b0, imem_req_valid}, 64'd0);
            sb.delete();
            exp_pc = redirect_pc & ~64'h3;
         end else begin
            if (fire) begin
               e.inst = mem_word(exp_pc);
               e.pc   = exp_pc;
               sb.push_back(e);
               exp_pc = exp_pc + 64'd4;
            end
            if (id_valid && id_ready) begin
               if (sb.size() == 0) begin
                  check("unexpected_id", {63'b0, id_valid}, 64'd0);
               end else begin
                  e = sb.pop_front();
                  check("id_pc", id_pc, e.pc);
                  check("id_inst", {32'b0, id_inst}, {32'b0, e.inst});
               end
            end
         end
      end
      @(posedge clk);
      #1;
      if (rst_s) begin
         pend.delete();
         imem_resp_valid = 1'b0;
      end else begin
         if (fire) pend.push_back(addr);
         if (pend.size() > MAX_OUTSTANDING) out_overflow = 1'b1;
         if (!hold && pend.size() > 0) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_word(pend.pop_front());
         end else begin
            imem_resp_valid = 1'b0;
         end
      end
   endtask

   initial begin
      rst             = 1'b1;
      redirect_valid  = 1'b0;
      redirect_pc     = '0;
      imem_req_ready  = 1'b1;
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
      id_ready        = 1'b0;

      // Reset
      repeat (3) tick();
      #1;
      check("rst_req_valid", {63'b0, imem_req_valid}, 64'd0);
      check("rst_id_valid", {63'b0, id_valid}, 64'd0);
      check("rst_id_inst", {32'b0, id_inst}, 64'd0);
      check("rst_id_pc", id_pc, 64'd0);
      rst = 1'b0;
      #1;
      check("first_req_valid", {63'b0, imem_req_valid}, 64'd1);
      check("first_req_addr", imem_req_addr, 64'h8000_0000);
      check("first_id_valid", {63'b0, id_valid}, 64'd0);

      // Streaming
      id_ready = 1'b1;
      tick();
      check("c1_id_valid", {63'b0, id_valid}, 64'd0);
      tick();
      check("c2_id_valid", {63'b0, id_valid}, 64'd1);
      check("c2_id_pc", id_pc, 64'h8000_0000);
      check("c2_id_inst", {32'b0, id_inst}, 64'h0010_0093);
      repeat (10) tick();

      // Backpressure after a mid-operation reset
      rst = 1'b1;
      tick();
      rst = 1'b0;
      id_ready = 1'b0;
      repeat (8) tick();
      check("bp_req_valid", {63'b0, imem_req_valid}, 64'd0);
      check("bp_req_addr", imem_req_addr, 64'h8000_0008);
      check("bp_pend", 64'(pend.size()), 64'd0);
      check("bp_id_valid", {63'b0, id_valid}, 64'd1);
      check("bp_id_pc", id_pc, 64'h8000_0000);
      id_ready = 1'b1;
      repeat (12) tick();

      // Redirect with two requests in flight
      hold = 1'b1;
      for (int i = 0; i < 12 && pend.size() < 2; i++) tick();
      check("rd1_two_pending", 64'(pend.size()), 64'd2);
      redirect_valid = 1'b1;
      redirect_pc    = 64'h8000_1002;
      #1;
      check("rd1_req_valid", {63'b0, imem_req_valid}, 64'd0);
      tick();
      redirect_valid = 1'b0;
      #1;
      check("rd1_next_addr", imem_req_addr, 64'h8000_1000);
      hold = 1'b0;
      for (int i = 0; i < 20 && !id_valid; i++) tick();
      check("rd1_id_valid", {63'b0, id_valid}, 64'd1);
      check("rd1_id_pc", id_pc, 64'h8000_1000);
      check("rd1_id_inst", {32'b0, id_inst}, {32'b0, mem_word(64'h8000_1000)});
      repeat (6) tick();

      // Redirect coincident with a response
      hold = 1'b1;
      for (int i = 0; i < 12 && pend.size() < 2; i++) tick();
      check("rd2_two_pending", 64'(pend.size()), 64'd2);
      hold = 1'b0;
      tick();
      redirect_valid = 1'b1;
      redirect_pc    = 64'h8000_2000;
      #1;
      check("rd2_resp_in_redirect", {63'b0, imem_resp_valid}, 64'd1);
      tick();
      redirect_valid = 1'b0;
      #1;
      check("rd2_req_valid", {63'b0, imem_req_valid}, 64'd1);
      check("rd2_req_addr", imem_req_addr, 64'h8000_2000);
      for (int i = 0; i < 20 && !id_valid; i++) tick();
      check("rd2_id_valid", {63'b0, id_valid}, 64'd1);
      check("rd2_id_pc", id_pc, 64'h8000_2000);
      repeat (6) tick();

      // imem stall
      imem_req_ready = 1'b0;
      repeat (4) tick();
      for (int i = 0; i < 5; i++) begin
         #1;
         check("stall_req_valid", {63'b0, imem_req_valid}, 64'd1);
         check("stall_addr", imem_req_addr, exp_pc);
         check("stall_id_valid", {63'b0, id_valid}, 64'd0);
         tick();
      end
      imem_req_ready = 1'b1;
      repeat (10) tick();

      check("no_push_into_full", {63'b0, q_overflow}, 64'd0);
      check("outstanding_limit", {63'b0, out_overflow}, 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
